// File: rtl/clock_pkg.sv
// Shared definitions for the BCD alarm clock: mode encodings, BCD field
// offsets inside the packed time/alarm buses, and a mode decode helper.
package clock_pkg;

    // Two-digit packed BCD field {tens, ones}
    typedef logic [7:0] bcd2_t;

    // Operating modes on i_mode
    localparam logic [2:0] MODE_RUN        = 3'd0;
    localparam logic [2:0] MODE_SET_HR     = 3'd1;
    localparam logic [2:0] MODE_SET_MIN    = 3'd2;
    localparam logic [2:0] MODE_CLR_SEC    = 3'd3;
    localparam logic [2:0] MODE_SET_AL_HR  = 3'd4;
    localparam logic [2:0] MODE_SET_AL_MIN = 3'd5;

    // Field offsets within o_time_bcd {H1,H0,M1,M0,S1,S0}
    localparam int TIME_SEC_LSB  = 0;
    localparam int TIME_MIN_LSB  = 8;
    localparam int TIME_HR_LSB   = 16;

    // Field offsets within o_alarm_bcd {H1,H0,M1,M0}
    localparam int ALARM_MIN_LSB = 0;
    localparam int ALARM_HR_LSB  = 8;

    // Unused codes (6, 7) behave as RUN
    function automatic logic [2:0] mode_decode(input logic [2:0] m);
        return (m > MODE_SET_AL_MIN) ? MODE_RUN : m;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Two-digit BCD counter that wraps from MAX back to MIN. Offers increment,
// synchronous load and a same-cycle carry-out so counters can ripple.
module bcd_digit_counter #(
    parameter logic [7:0] MAX  = 8'h59,
    parameter logic [7:0] MIN  = 8'h00,
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_en,
    input  logic       i_inc,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic [7:0] o_value,
    output logic [7:0] o_next,
    output logic       o_carry
);

    logic [7:0] val_q;
    logic [7:0] inc_val;

    // BCD successor of the current value, wrapping MAX -> MIN
    always_comb begin
        inc_val = val_q;
        if (val_q == MAX)
            inc_val = MIN;
        else if (val_q[3:0] == 4'd9)
            inc_val = {val_q[7:4] + 4'd1, 4'd0};
        else
            inc_val = {val_q[7:4], val_q[3:0] + 4'd1};
    end

    // Next value: load beats increment, everything holds while disabled
    always_comb begin
        o_next = val_q;
        if (i_en) begin
            if (i_load)
                o_next = i_load_val;
            else if (i_inc)
                o_next = inc_val;
        end
    end

    // Value register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            val_q <= INIT;
        else
            val_q <= o_next;
    end

    assign o_value = val_q;
    assign o_carry = i_en & i_inc & ~i_load & (val_q == MAX);

endmodule

// File: rtl/bcd_alarm_clock.sv
// BCD time-of-day clock with settable time, alarm compare, alarm timeout and
// a change strobe. 24-hour or 12-hour (with PM flag) selected by HOUR_12.
module bcd_alarm_clock
    import clock_pkg::*;
#(
    parameter bit          HOUR_12         = 1'b0,
    parameter int unsigned ALARM_TIMEOUT_S = 60
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_en,
    input  logic        i_1hz_stb,
    input  logic        i_timeset_stb,
    input  logic [2:0]  i_mode,
    input  logic        i_alarm_en,
    input  logic        i_alarm_ack,
    output logic [23:0] o_time_bcd,
    output logic        o_pm,
    output logic [15:0] o_alarm_bcd,
    output logic        o_alarm_pm,
    output logic        o_alarm_active,
    output logic        o_update_stb
);

    localparam bcd2_t      HR_MAX  = HOUR_12 ? 8'h12 : 8'h23;
    localparam bcd2_t      HR_MIN  = HOUR_12 ? 8'h01 : 8'h00;
    localparam bcd2_t      HR_INIT = HOUR_12 ? 8'h12 : 8'h00;
    localparam logic [7:0] TO_LAST = 8'(ALARM_TIMEOUT_S - 1);

    logic [2:0] mode;
    logic       run_cnt, tick, set;

    bcd2_t sec_q, sec_next, min_q, min_next, hr_q, hr_next;
    bcd2_t al_min_q, al_min_next, al_hr_q, al_hr_next;
    logic  sec_carry, min_carry, hr_carry, al_min_carry, al_hr_carry;
    logic  sec_load, min_inc, hr_inc, al_min_inc, al_hr_inc;
    logic  pm_q, pm_next, al_pm_q, al_pm_next;

    logic       time_chg, match, trigger, timeout_hit, clear;
    logic       active_q, stb_q;
    logic [7:0] to_cnt_q;
    logic       unused_carries;

    assign mode    = mode_decode(i_mode);
    // Time keeps running while the alarm is being edited
    assign run_cnt = (mode == MODE_RUN) | (mode == MODE_SET_AL_HR) | (mode == MODE_SET_AL_MIN);
    assign tick    = i_1hz_stb & run_cnt;
    assign set     = i_timeset_stb;

    // Seconds: ripple source, forced to 00 in CLR_SEC
    assign sec_load = set & (mode == MODE_CLR_SEC);

    bcd_digit_counter #(.MAX(8'h59), .MIN(8'h00), .INIT(8'h00)) u_sec (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_en       (i_en),
        .i_inc      (tick),
        .i_load     (sec_load),
        .i_load_val (8'h00),
        .o_value    (sec_q),
        .o_next     (sec_next),
        .o_carry    (sec_carry)
    );

    // Minutes: carry from seconds, or direct edit without carrying into hours
    assign min_inc = (tick & sec_carry) | (set & (mode == MODE_SET_MIN));

    bcd_digit_counter #(.MAX(8'h59), .MIN(8'h00), .INIT(8'h00)) u_min (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_en       (i_en),
        .i_inc      (min_inc),
        .i_load     (1'b0),
        .i_load_val (8'h00),
        .o_value    (min_q),
        .o_next     (min_next),
        .o_carry    (min_carry)
    );

    // Hours: full ripple carry only when counting, direct edit in SET_HR
    assign hr_inc = (tick & sec_carry & min_carry) | (set & (mode == MODE_SET_HR));

    bcd_digit_counter #(.MAX(HR_MAX), .MIN(HR_MIN), .INIT(HR_INIT)) u_hr (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_en       (i_en),
        .i_inc      (hr_inc),
        .i_load     (1'b0),
        .i_load_val (8'h00),
        .o_value    (hr_q),
        .o_next     (hr_next),
        .o_carry    (hr_carry)
    );

    // Alarm minute and hour, edited only
    assign al_min_inc = set & (mode == MODE_SET_AL_MIN);
    assign al_hr_inc  = set & (mode == MODE_SET_AL_HR);

    bcd_digit_counter #(.MAX(8'h59), .MIN(8'h00), .INIT(8'h00)) u_al_min (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_en       (i_en),
        .i_inc      (al_min_inc),
        .i_load     (1'b0),
        .i_load_val (8'h00),
        .o_value    (al_min_q),
        .o_next     (al_min_next),
        .o_carry    (al_min_carry)
    );

    bcd_digit_counter #(.MAX(HR_MAX), .MIN(HR_MIN), .INIT(HR_INIT)) u_al_hr (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_en       (i_en),
        .i_inc      (al_hr_inc),
        .i_load     (1'b0),
        .i_load_val (8'h00),
        .o_value    (al_hr_q),
        .o_next     (al_hr_next),
        .o_carry    (al_hr_carry)
    );

    // Hour wrap carries are not needed: there is no day counter
    assign unused_carries = hr_carry | al_min_carry | al_hr_carry;

    // PM flips on the 11 -> 12 step, whether reached by ripple or by edit
    assign pm_next    = pm_q    ^ (HOUR_12 & i_en & hr_inc    & (hr_q    == 8'h11));
    assign al_pm_next = al_pm_q ^ (HOUR_12 & i_en & al_hr_inc & (al_hr_q == 8'h11));

    // PM flag registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pm_q    <= 1'b0;
            al_pm_q <= 1'b0;
        end else begin
            pm_q    <= pm_next;
            al_pm_q <= al_pm_next;
        end
    end

    // Alarm compares against the post-update time so it rises with the change
    assign time_chg = ({hr_next, min_next, sec_next} != {hr_q, min_q, sec_q}) | (pm_next != pm_q);
    assign match    = (hr_next == al_hr_next) & (min_next == al_min_next) &
                      (sec_next == 8'h00) & (pm_next == al_pm_next);
    assign trigger  = time_chg & i_alarm_en & match;

    assign timeout_hit = active_q & i_1hz_stb & (to_cnt_q == TO_LAST);
    assign clear       = i_alarm_ack | ~i_alarm_en | timeout_hit;

    // Ring state and timeout: clear beats trigger, every trigger restarts the count
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            active_q <= 1'b0;
            to_cnt_q <= 8'd0;
        end else if (i_en) begin
            if (clear) begin
                active_q <= 1'b0;
                to_cnt_q <= 8'd0;
            end else if (trigger) begin
                active_q <= 1'b1;
                to_cnt_q <= 8'd0;
            end else if (active_q && i_1hz_stb) begin
                to_cnt_q <= to_cnt_q + 8'd1;
            end
        end
    end

    // Change strobe; time_chg is 0 while disabled so no stale pulse survives
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            stb_q <= 1'b0;
        else
            stb_q <= time_chg;
    end

    assign o_time_bcd[TIME_HR_LSB  +: 8] = hr_q;
    assign o_time_bcd[TIME_MIN_LSB +: 8] = min_q;
    assign o_time_bcd[TIME_SEC_LSB +: 8] = sec_q;
    assign o_alarm_bcd[ALARM_HR_LSB  +: 8] = al_hr_q;
    assign o_alarm_bcd[ALARM_MIN_LSB +: 8] = al_min_q;

    assign o_pm           = HOUR_12 ? pm_q    : 1'b0;
    assign o_alarm_pm     = HOUR_12 ? al_pm_q : 1'b0;
    assign o_alarm_active = active_q;
    assign o_update_stb   = stb_q & i_en;

endmodule

// File: tb/tb_bcd_alarm_clock.sv
// Directed bench: a 24-hour and a 12-hour instance share one stimulus stream.
module tb_bcd_alarm_clock;

    logic        clk = 1'b0;
    logic        rst_n, en, hz, ts, al_en, ack;
    logic [2:0]  mode;

    logic [23:0] t24, t12;
    logic [15:0] a24, a12;
    logic        pm24, pm12, apm24, apm12, act24, act12, stb24, stb12;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bcd_alarm_clock #(.HOUR_12(1'b0), .ALARM_TIMEOUT_S(60)) d24 (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_1hz_stb(hz),
        .i_timeset_stb(ts), .i_mode(mode), .i_alarm_en(al_en), .i_alarm_ack(ack),
        .o_time_bcd(t24), .o_pm(pm24), .o_alarm_bcd(a24), .o_alarm_pm(apm24),
        .o_alarm_active(act24), .o_update_stb(stb24)
    );

    bcd_alarm_clock #(.HOUR_12(1'b1), .ALARM_TIMEOUT_S(60)) d12 (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_1hz_stb(hz),
        .i_timeset_stb(ts), .i_mode(mode), .i_alarm_en(al_en), .i_alarm_ack(ack),
        .o_time_bcd(t12), .o_pm(pm12), .o_alarm_bcd(a12), .o_alarm_pm(apm12),
        .o_alarm_active(act12), .o_update_stb(stb12)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            hz = 1'b1;
            step();
            hz = 1'b0;
        end
    endtask

    task automatic setp(input int n);
        for (int i = 0; i < n; i++) begin
            ts = 1'b1;
            step();
            ts = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b1; hz = 1'b0; ts = 1'b0;
        mode = 3'd0; al_en = 1'b0; ack = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    // Alarm 07:00, time 06:59:59, alarm armed, not yet ringing
    task automatic ring_setup();
        do_reset();
        mode = 3'd4; setp(7);
        mode = 3'd1; setp(6);
        mode = 3'd2; setp(59);
        mode = 3'd0; tick(59);
        al_en = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        check("rst_time24", 32'(t24),   32'h000000);
        check("rst_time12", 32'(t12),   32'h120000);
        check("rst_pm12",   32'(pm12),  32'h0);
        check("rst_al24",   32'(a24),   32'h0000);
        check("rst_al12",   32'(a12),   32'h1200);
        check("rst_apm12",  32'(apm12), 32'h0);
        check("rst_act",    32'({act24, act12}), 32'h0);
        check("rst_stb",    32'({stb24, stb12}), 32'h0);

        // tick and alarm edit in the same cycle
        mode = 3'd5; hz = 1'b1; ts = 1'b1; step(); hz = 1'b0; ts = 1'b0;
        check("both_time24", 32'(t24), 32'h000001);
        check("both_al24",   32'(a24), 32'h0001);
        check("both_al12",   32'(a12), 32'h1201);
        check("both_stb",    32'(stb24), 32'h1);

        // disabled: nothing moves, no strobe
        en = 1'b0; mode = 3'd0; tick(1); setp(1);
        check("dis_time24", 32'(t24),   32'h000001);
        check("dis_stb",    32'(stb24), 32'h0);
        en = 1'b1;
        mode = 3'd7; tick(1);
        check("mode7_run", 32'(t24), 32'h000002);

        // 24-hour midnight wrap
        do_reset();
        mode = 3'd1; setp(23);
        mode = 3'd2; setp(59);
        mode = 3'd0; tick(58);
        check("w24_pre",   32'(t24), 32'h235958);
        check("w12_pre",   32'({pm12, t12}), 32'h1115958);
        tick(1);
        check("w24_t1",    32'(t24),   32'h235959);
        check("w24_stb1",  32'(stb24), 32'h1);
        step();
        check("w24_idle1", 32'(stb24), 32'h0);
        tick(1);
        check("w24_t2",    32'(t24),   32'h000000);
        check("w24_stb2",  32'(stb24), 32'h1);
        check("w12_mid",   32'({pm12, t12}), 32'h0120000);
        step();
        check("w24_idle2", 32'(stb24), 32'h0);

        // 12-hour noon and 12->1 rollover
        do_reset();
        mode = 3'd1; setp(11);
        mode = 3'd2; setp(59);
        mode = 3'd0; tick(59);
        check("n12_pre",  32'({pm12, t12}), 32'h0115959);
        tick(1);
        check("n12_noon", 32'({pm12, t12}), 32'h1120000);
        check("n24_noon", 32'({pm24, t24}), 32'h0120000);
        mode = 3'd2; setp(59);
        mode = 3'd0; tick(59);
        check("n12_pre1", 32'({pm12, t12}), 32'h1125959);
        tick(1);
        check("n12_one",  32'({pm12, t12}), 32'h1010000);
        check("n24_13",   32'(t24), 32'h130000);

        // SET_MIN: no carry into hours, seconds frozen
        do_reset();
        mode = 3'd1; setp(10);
        mode = 3'd2; setp(59);
        mode = 3'd0; tick(30);
        check("sm_pre",  32'(t24), 32'h105930);
        mode = 3'd2; setp(1);
        check("sm_wrap", 32'(t24), 32'h100030);
        tick(5);
        check("sm_hold", 32'(t24), 32'h100030);
        check("sm_stb",  32'(stb24), 32'h0);

        // alarm trigger and timeout
        ring_setup();
        check("al_pre",   32'({act24, act12}), 32'h0);
        check("al_time",  32'(t24), 32'h065959);
        tick(1);
        check("al_hit",   32'(t24), 32'h070000);
        check("al_rise",  32'({act24, act12}), 32'h3);
        tick(59);
        check("al_59",    32'({act24, act12}), 32'h3);
        tick(1);
        check("al_60",    32'({act24, act12}), 32'h0);

        // ack vs retrigger, ack, disarm, async reset
        ring_setup();
        tick(1);
        check("rt_rise",  32'(act24), 32'h1);
        tick(3);
        mode = 3'd3; ack = 1'b1; setp(1); ack = 1'b0;
        check("rt_time",  32'(t24), 32'h070000);
        check("rt_ackwin", 32'({act24, act12}), 32'h0);
        mode = 3'd0; tick(2);
        mode = 3'd3; setp(1);
        check("rt_again", 32'(act24), 32'h1);
        ack = 1'b1; step(); ack = 1'b0;
        check("rt_ack",   32'(act24), 32'h0);
        mode = 3'd0; tick(1);
        mode = 3'd3; setp(1);
        check("rt_again2", 32'(act24), 32'h1);
        al_en = 1'b0; step(); al_en = 1'b1;
        check("rt_disarm", 32'(act24), 32'h0);
        mode = 3'd0; tick(1);
        mode = 3'd3; setp(1);
        check("rt_again3", 32'({act24, act12}), 32'h3);
        #2 rst_n = 1'b0;
        #2;
        check("ar_act",    32'({act24, act12}), 32'h0);
        check("ar_time24", 32'(t24), 32'h000000);
        check("ar_time12", 32'(t12), 32'h120000);
        step();
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
